// File: rtl/mips_mem_pkg.sv
// Shared definitions for the load/store unit:
// access-size encodings, FSM states and the memory depth.
package mips_mem_pkg;

  localparam int unsigned MEM_WORDS_DEF = 85;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    S_IDLE,
    S_RMW_WRITE
  } lsu_state_e;

endpackage

// File: rtl/subword_align.sv
// Little-endian lane handling: load extraction/extension
// and store merge into the current memory word.
module subword_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merged_o
);

  logic [4:0]  bsh;
  logic [4:0]  hsh;
  logic [7:0]  b;
  logic [15:0] h;

  assign bsh = {lane_i, 3'b000};
  assign hsh = {lane_i[1], 4'b0000};
  assign b   = 8'(word_i >> bsh);
  assign h   = 16'(word_i >> hsh);

  always_comb begin
    load_o   = '0;
    merged_o = word_i;
    unique case (1'b1)
      (size_i == SZ_BYTE): begin
        load_o   = {{24{b[7] & ~unsigned_i}}, b};
        merged_o = (word_i & ~(32'h0000_00ff << bsh))
                 | ({24'b0, wdata_i[7:0]} << bsh);
      end
      (size_i == SZ_HALF): begin
        load_o   = {{16{h[15] & ~unsigned_i}}, h};
        merged_o = (word_i & ~(32'h0000_ffff << hsh))
                 | ({16'b0, wdata_i[15:0]} << hsh);
      end
      (size_i == SZ_WORD): begin
        load_o   = word_i;
        merged_o = wdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-wide data
// memory; sub-word stores go through a 2-cycle read-modify-write.
module load_store_unit
  import mips_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEF,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              fault,
  output logic [ADDR_W-1:0] mem_a,
  output logic [31:0]       mem_wd,
  output logic              mem_we,
  input  logic [31:0]       mem_rd
);

  lsu_state_e        state_q, state_d;
  logic [31:0]       merged_q, merged_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  logic [ADDR_W-1:0] idx;
  logic              misal;
  logic              bad_size;
  logic              oor;
  logic              req_fault;
  logic [31:0]       load_data;
  logic [31:0]       merged;

  assign idx       = req_addr >> 2;
  assign misal     = (req_size == SZ_HALF && req_addr[0])
                   || (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
  assign bad_size  = (req_size == 2'b11);
  assign oor       = (idx >= ADDR_W'(MEM_WORDS));
  assign req_fault = misal | bad_size | oor;

  subword_align u_align (
    .size_i     (req_size),
    .unsigned_i (req_unsigned),
    .lane_i     (req_addr[1:0]),
    .word_i     (mem_rd),
    .wdata_i    (req_wdata),
    .load_o     (load_data),
    .merged_o   (merged)
  );

  always_comb begin
    state_d  = state_q;
    merged_d = merged_q;
    idx_d    = idx_q;
    rdata    = '0;
    stall    = 1'b0;
    fault    = 1'b0;
    mem_we   = 1'b0;
    mem_a    = idx;
    mem_wd   = req_wdata;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_fault) begin
            fault = 1'b1;
          end else if (!req_we) begin
            rdata = load_data;
          end else if (req_size == SZ_WORD) begin
            mem_we = 1'b1;
          end else begin
            stall    = 1'b1;
            merged_d = merged;
            idx_d    = idx;
            state_d  = S_RMW_WRITE;
          end
        end
      end
      S_RMW_WRITE: begin
        mem_a   = idx_q;
        mem_wd  = merged_q;
        mem_we  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // reset must also suppress a pending RMW write
    if (reset) begin
      rdata  = '0;
      stall  = 1'b0;
      fault  = 1'b0;
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      merged_q <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      merged_q <= merged_d;
      idx_q    <= idx_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with an architectural
// memory model checked every cycle plus literal expectations.
module tb_load_store_unit;
  import mips_mem_pkg::*;

  localparam int NW = 85;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        fault;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rdata        (rdata),
    .stall        (stall),
    .fault        (fault),
    .mem_a        (mem_a),
    .mem_wd       (mem_wd),
    .mem_we       (mem_we),
    .mem_rd       (mem_rd)
  );

  // environment: the word-wide data memory itself
  logic [31:0] mem [0:NW-1];
  assign mem_rd = (mem_a < NW) ? mem[mem_a[6:0]] : 32'h0;
  always @(posedge clk) if (mem_we && mem_a < NW) mem[mem_a[6:0]] <= mem_wd;

  // architectural model: memory image plus one pending sub-word write
  logic [31:0] gmem [0:NW-1];
  bit          pend = 0;
  int          pidx;
  logic [31:0] pval;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_fault(input logic [1:0] sz, input logic [31:0] a);
    return sz == 2'b11 || (sz == SZ_HALF && a % 2 != 0)
        || (sz == SZ_WORD && a % 4 != 0) || a / 4 >= NW;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] w,
      input logic [1:0] sz, input logic u, input logic [31:0] a);
    int sh;
    logic [31:0] v;
    sh = 8 * int'(a % 4);
    if (sz == SZ_WORD) return w;
    if (sz == SZ_BYTE) begin
      v = (w >> sh) & 32'hFF;
      if (!u && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else begin
      v = (w >> sh) & 32'hFFFF;
      if (!u && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] exp_merge(input logic [31:0] w,
      input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int sh;
    logic [31:0] m;
    sh = 8 * int'(a % 4);
    m = ((sz == SZ_BYTE) ? 32'hFF : 32'hFFFF) << sh;
    return (w & ~m) | ((d << sh) & m);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      pend = 0;
    end else if (pend) begin
      gmem[pidx] = pval;
      pend = 0;
    end else if (req_valid && !exp_fault(req_size, req_addr) && req_we) begin
      if (req_size == SZ_WORD) begin
        gmem[req_addr / 4] = req_wdata;
      end else begin
        pidx = int'(req_addr / 4);
        pval = exp_merge(gmem[pidx], req_size, req_addr, req_wdata);
        pend = 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] e_rd, e_a, e_wd;
    logic e_st, e_we, e_f, c_a, c_rd;
    e_rd = 0; e_a = 0; e_wd = 0;
    e_st = 0; e_we = 0; e_f = 0; c_a = 0; c_rd = 1;
    if (reset) begin
      c_rd = 0;
    end else if (pend) begin
      e_we = 1; e_a = pidx; e_wd = pval; c_a = 1;
    end else if (req_valid) begin
      if (exp_fault(req_size, req_addr)) begin
        e_f = 1;
      end else begin
        e_a = req_addr / 4; c_a = 1;
        if (!req_we) begin
          e_rd = exp_load(gmem[e_a], req_size, req_unsigned, req_addr);
        end else if (req_size == SZ_WORD) begin
          e_we = 1; e_wd = req_wdata;
        end else begin
          e_st = 1;
        end
      end
    end
    chk("m_stall", 32'(stall), 32'(e_st));
    chk("m_we", 32'(mem_we), 32'(e_we));
    chk("m_fault", 32'(fault), 32'(e_f));
    if (c_rd) chk("m_rdata", rdata, e_rd);
    if (c_a) chk("m_addr", mem_a, e_a);
    if (e_we) chk("m_wd", mem_wd, e_wd);
  end

  task automatic step(input logic rst, input logic v, input logic we,
      input logic [1:0] sz, input logic u, input logic [31:0] a,
      input logic [31:0] d);
    @(posedge clk);
    #1;
    reset = rst; req_valid = v; req_we = we; req_size = sz;
    req_unsigned = u; req_addr = a; req_wdata = d;
    @(negedge clk);
  endtask

  initial begin
    int bad;
    reset = 1; req_valid = 0; req_we = 0; req_size = 0;
    req_unsigned = 0; req_addr = 0; req_wdata = 0;
    for (int i = 0; i < NW; i++) begin
      mem[i]  = 32'h1000_0000 + i * 32'h0001_0203;
      gmem[i] = 32'h1000_0000 + i * 32'h0001_0203;
    end
    mem[3]  = 32'h8899_AABB;
    gmem[3] = 32'h8899_AABB;

    step(1, 1, 1, SZ_WORD, 0, 32'h0, 32'h5);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_we", 32'(mem_we), 0);
    step(1, 0, 0, SZ_WORD, 0, 32'h0, 32'h0);
    chk("rst_fault", 32'(fault), 0);

    step(0, 1, 0, SZ_BYTE, 0, 32'h0D, 0);
    chk("lb_0d", rdata, 32'hFFFF_FFAA);
    chk("lb_stall", 32'(stall), 0);
    step(0, 1, 0, SZ_BYTE, 1, 32'h0D, 0);
    chk("lbu_0d", rdata, 32'h0000_00AA);

    step(0, 1, 1, SZ_BYTE, 0, 32'h0E, 32'h11);
    chk("sb_c1_stall", 32'(stall), 1);
    chk("sb_c1_we", 32'(mem_we), 0);
    step(0, 0, 0, SZ_WORD, 0, 32'h0, 0);
    chk("sb_c2_we", 32'(mem_we), 1);
    chk("sb_c2_wd", mem_wd, 32'h8811_AABB);
    chk("sb_c2_a", mem_a, 32'd3);
    step(0, 1, 0, SZ_WORD, 0, 32'h0C, 0);
    chk("lw_after_sb", rdata, 32'h8811_AABB);

    step(0, 1, 1, SZ_HALF, 0, 32'h0C, 32'h1234);
    chk("b2b_st0", 32'(stall), 1);
    step(0, 1, 1, SZ_HALF, 0, 32'h0C, 32'h1234);
    chk("b2b_st1", 32'(stall), 0);
    chk("b2b_wd1", mem_wd, 32'h8811_1234);
    step(0, 1, 1, SZ_BYTE, 0, 32'h0F, 32'h56);
    chk("b2b_st2", 32'(stall), 1);
    step(0, 1, 1, SZ_BYTE, 0, 32'h0F, 32'h56);
    chk("b2b_st3", 32'(stall), 0);
    step(0, 1, 0, SZ_WORD, 0, 32'h0C, 0);
    chk("b2b_final", rdata, 32'h5611_1234);

    step(0, 1, 0, SZ_WORD, 0, 32'h06, 0);
    chk("mis_lw", 32'(fault), 1);
    chk("mis_lw_stall", 32'(stall), 0);
    step(0, 1, 1, SZ_HALF, 0, 32'h05, 32'hFFFF);
    chk("mis_sh", 32'(fault), 1);
    chk("mis_sh_we", 32'(mem_we), 0);
    step(0, 1, 0, SZ_WORD, 0, 32'h154, 0);
    chk("oor_lw", 32'(fault), 1);
    step(0, 1, 0, 2'b11, 0, 32'h0, 0);
    chk("bad_size", 32'(fault), 1);
    step(0, 1, 0, SZ_WORD, 0, 32'h150, 0);
    chk("last_ok", 32'(fault), 0);

    step(0, 1, 1, SZ_BYTE, 0, 32'h0C, 32'hFF);
    chk("rrmw_stall", 32'(stall), 1);
    step(1, 1, 1, SZ_BYTE, 0, 32'h0C, 32'hFF);
    chk("rrmw_we", 32'(mem_we), 0);
    step(0, 0, 0, SZ_WORD, 0, 32'h0, 0);
    chk("rrmw_idle", 32'(stall | mem_we), 0);
    step(0, 1, 0, SZ_WORD, 0, 32'h0C, 0);
    chk("rrmw_mem", rdata, 32'h5611_1234);

    step(0, 1, 1, SZ_WORD, 0, 32'h08, 32'hDEAD_BEEF);
    chk("sw_we", 32'(mem_we), 1);
    chk("sw_a", mem_a, 32'd2);
    chk("sw_stall", 32'(stall), 0);
    step(0, 1, 0, SZ_WORD, 0, 32'h08, 0);
    chk("lw_dead", rdata, 32'hDEAD_BEEF);
    step(0, 1, 0, SZ_HALF, 0, 32'h0A, 0);
    chk("lh_0a", rdata, 32'hFFFF_DEAD);
    step(0, 1, 0, SZ_HALF, 1, 32'h0A, 0);
    chk("lhu_0a", rdata, 32'h0000_DEAD);
    step(0, 1, 0, SZ_BYTE, 0, 32'h08, 0);
    chk("lb_08", rdata, 32'hFFFF_FFEF);
    step(0, 1, 0, SZ_BYTE, 1, 32'h09, 0);
    chk("lbu_09", rdata, 32'h0000_00BE);
    step(0, 1, 0, SZ_HALF, 0, 32'h0E, 0);
    chk("lh_0e", rdata, 32'h0000_5611);

    step(0, 1, 1, SZ_WORD, 0, 32'h150, 32'hCAFE_F00D);
    step(0, 1, 0, SZ_WORD, 0, 32'h150, 0);
    chk("lw_last", rdata, 32'hCAFE_F00D);
    step(0, 1, 1, SZ_HALF, 0, 32'h152, 32'hBEEF);
    step(0, 0, 0, SZ_WORD, 0, 32'h0, 0);
    step(0, 1, 0, SZ_WORD, 0, 32'h150, 0);
    chk("sh_last", rdata, 32'hBEEF_F00D);
    step(0, 0, 0, SZ_WORD, 0, 32'h0, 0);

    bad = 0;
    for (int i = 0; i < NW; i++) if (mem[i] !== gmem[i]) bad++;
    chk("mem_image", 32'(bad), 0);
    chk("mem3_final", mem[3], 32'h5611_1234);
    chk("mem2_final", mem[2], 32'hDEAD_BEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the core's execute stage and the word-addressed data memory: converts byte addresses to word indices, extracts and extends loaded bytes and halfwords, and merges byte and halfword stores.
- Data memory is word-wide only: combinational read, write on the clock edge. Sub-word stores therefore use a 2-cycle read-modify-write (RMW) and stall the core.
- Loads and word stores complete in 1 cycle.

Parameters:
- MEM_WORDS, 85, number of words in data memory; word index >= MEM_WORDS is an access fault.
- ADDR_W, 32, width of byte address and memory index.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  memory instruction present this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal and treated as a fault.
- req_unsigned  in  1  zero-extend the load (lbu/lhu) when 1.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- rdata  out  32  extended load result, combinational.
- stall  out  1  core must hold PC and request while 1.
- fault  out  1  misaligned, out-of-range or illegal size; combinational, same cycle.
- mem_a  out  32  word index to memory, equal to req_addr >> 2.
- mem_wd  out  32  write data to memory.
- mem_we  out  1  memory write enable.
- mem_rd  in  32  memory read data, combinational.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- Endianness: little-endian lanes. Byte lane = addr[1:0], lane 0 = bits 7:0. Half lane = addr[1], 0 = bits 15:0.
- Fault conditions: half with addr[0]=1; word with addr[1:0]!=0; size=11; word index >= MEM_WORDS.
- On fault: mem_we=0, rdata=0, stall=0, no FSM transition. The core owns the exception.
- FSM states: IDLE, RMW_WRITE.
- IDLE, load: mem_a=index, mem_we=0, stall=0. rdata = selected lane, sign- or zero-extended per req_unsigned. Word loads pass through unchanged.
- IDLE, word store: mem_we=1, mem_wd=req_wdata, stall=0. Completes in 1 cycle.
- IDLE, byte/half store: mem_we=0, stall=1, mem_a=index.
  - Register merged = mem_rd with the target lane replaced by the low bits of req_wdata.
  - Register the index.
  - Go to RMW_WRITE.
- RMW_WRITE: mem_a = registered index, mem_wd = merged, mem_we=1, stall=0; return to IDLE next edge.
  - Inputs are ignored in this state; the write completes even if req_valid drops.
  - rdata=0.
- req_valid=0 in IDLE: mem_we=0, stall=0, rdata=0.
- Reset values: state IDLE, merged register 0, index register 0.
  - While reset=1: mem_we=0, stall=0, fault=0 (all forced).
- Reset asserted in RMW_WRITE: no write occurs; state returns to IDLE.
- Latency:
  - Load: 0 cycles, rdata valid in the request cycle.
  - Word store: 1 edge.
  - Sub-word store: 2 edges, stall high exactly 1 cycle.
- Back-to-back sub-word stores: each takes 2 cycles. The second store reads the first store's result, because the memory write lands before the second store's IDLE read.

Decomposition:
- Package mips_mem_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - the FSM state enum;
  - the MEM_WORDS default.
- Sub-module subword_align (combinational) does load lane extraction/extension and store lane merge. It is instantiated once, with the FSM in the top module.

Test Plan:
- Memory word 3 = 0x8899AABB. Load byte at addr 0x0D, signed -> rdata=0xFFFFFFAA, stall=0. Same load unsigned -> 0x000000AA.
- Byte store 0x11 to addr 0x0E, word 3 = 0x8899AABB -> cycle 1 stall=1, mem_we=0; cycle 2 mem_we=1, mem_wd=0x8811AABB. Reading word 3 afterwards returns 0x8811AABB.
- Half store 0x1234 to 0x0C, immediately followed by byte store 0x56 to 0x0F -> final word 3 = 0x56xx1234, with stall pattern 1,0,1,0.
- Word load at 0x06 and half store at 0x05 -> fault=1, mem_we=0, stall=0, memory unchanged. Word load at byte addr 85*4 -> fault=1.
- Reset asserted during RMW_WRITE of byte store -> no write edge, memory word unchanged, next cycle stall=0, state IDLE.
- Word store 0xDEADBEEF to 0x08 -> mem_we=1 in the same cycle, mem_a=2, no stall, next-cycle load returns 0xDEADBEEF.
